// File: rtl/fetch_port_pkg.sv
// Shared definitions for the instruction fetch port: default widths, the
// opcode-to-argument byte offset and the fetch FSM state encoding.
package fetch_port_pkg;

  localparam int FETCH_ADDR_W     = 16;
  localparam int FETCH_DATA_W     = 16;
  // Also used by the fetch unit's PC increment logic.
  localparam int FETCH_ARG_OFFSET = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPC   = 2'd1,
    ARG   = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_port_if.sv
// Bundle of fetch-unit and memory-bus signals for fetch_port.
// master = environment (fetch unit + memory), slave = fetch_port itself.
interface fetch_port_if
  import fetch_port_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
);

  // Handshakes: fetch side completes when fetch_req & ~hold (opc/arg valid that
  // cycle); memory side completes when mem_rd & mem_ready, and mem_rd/mem_addr
  // stay stable until then (only rst may drop them).
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_pc;
  logic              flush;
  logic [DATA_W-1:0] fetch_opc;
  logic [DATA_W-1:0] fetch_arg;
  logic              hold;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  fetch_state_e      dbg_state;

  modport master (
    output fetch_req, fetch_pc, flush, mem_rdata, mem_ready,
    input  fetch_opc, fetch_arg, hold, mem_addr, mem_rd, dbg_state
  );

  modport slave (
    input  fetch_req, fetch_pc, flush, mem_rdata, mem_ready,
    output fetch_opc, fetch_arg, hold, mem_addr, mem_rd, dbg_state
  );

endinterface

// File: rtl/fetch_port.sv
// Fetch port: buffers one opcode/argument word pair read over a wait-state bus.
// Optional FETCH_PREFETCH_EN reuses the previous argument word as the next opcode.
module fetch_port
  import fetch_port_pkg::*;
#(
  parameter int ADDR_W     = FETCH_ADDR_W,
  parameter int DATA_W     = FETCH_DATA_W,
  parameter int ARG_OFFSET = FETCH_ARG_OFFSET
) (
  input  logic         clk,
  input  logic         rst,
  fetch_port_if.slave  bus
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:1] tag_q;
  logic [ADDR_W-1:1] pc_q;
  logic [DATA_W-1:0] opc_q, arg_q;
  logic              v_q;
  logic              drain_arg_q;

  logic              hit, hold, consume, start, seq_hit;
  logic              opc_done, arg_done, flush_busy;
  logic [ADDR_W-1:0] opc_addr, arg_addr;

  assign hit        = v_q && (tag_q == bus.fetch_pc[ADDR_W-1:1]);
  assign hold       = bus.fetch_req && !(state_q == IDLE && hit && !bus.flush);
  assign consume    = bus.fetch_req && !hold;
  assign start      = (state_q == IDLE) && bus.fetch_req && !hit && !bus.flush;
  assign opc_done   = (state_q == OPC) && bus.mem_ready && !bus.flush;
  assign arg_done   = (state_q == ARG) && bus.mem_ready && !bus.flush;
  assign flush_busy = bus.flush && (state_q == OPC || state_q == ARG);
  assign opc_addr   = {pc_q, 1'b0};
  assign arg_addr   = opc_addr + ADDR_W'(ARG_OFFSET);

`ifdef FETCH_PREFETCH_EN
  logic              arg_v_q;
  logic [ADDR_W-2:0] next_word;

  // Word-sequential successor of the buffered opcode; wraps with the address space.
  assign next_word = tag_q + (ADDR_W-1)'(ARG_OFFSET / 2);
  assign seq_hit   = arg_v_q && (bus.fetch_pc[ADDR_W-1:1] == next_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      arg_v_q <= 1'b0;
    end else if (bus.flush) begin
      arg_v_q <= 1'b0;
    end else if (arg_done) begin
      arg_v_q <= 1'b1;
    end
  end
`else
  assign seq_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    bus.mem_rd   = 1'b0;
    bus.mem_addr = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = seq_hit ? ARG : OPC;
      end
      OPC: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = opc_addr;
        if (bus.flush)          state_d = DRAIN;
        else if (bus.mem_ready) state_d = ARG;
      end
      ARG: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = arg_addr;
        if (bus.flush)          state_d = DRAIN;
        else if (bus.mem_ready) state_d = IDLE;
      end
      DRAIN: begin
        // Keep presenting whichever read was cut short until the bus completes it.
        bus.mem_rd   = 1'b1;
        bus.mem_addr = drain_arg_q ? arg_addr : opc_addr;
        if (bus.mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      pc_q        <= '0;
      opc_q       <= '0;
      arg_q       <= '0;
      v_q         <= 1'b0;
      drain_arg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        pc_q <= bus.fetch_pc[ADDR_W-1:1];
        if (seq_hit) opc_q <= arg_q;
      end
      if (opc_done) opc_q <= bus.mem_rdata;
      if (arg_done) begin
        arg_q <= bus.mem_rdata;
        tag_q <= pc_q;
        v_q   <= 1'b1;
      end
      if (consume) v_q <= 1'b0;
      if (flush_busy) drain_arg_q <= (state_q == ARG);
      // Flush wins over consume and over a read completing in the same cycle.
      if (bus.flush) v_q <= 1'b0;
    end
  end

  assign bus.hold      = hold;
  assign bus.fetch_opc = opc_q;
  assign bus.fetch_arg = arg_q;
  assign bus.dbg_state = state_q;

endmodule
